// File: rtl/pdp8_bus_target.sv
// pdp8_bus_target
//   Target on the PDP-8 core's 8-bit multiplexed nibble bus. It decodes
//   address, IO-intro and data beats, owns a synchronous word RAM and one
//   IO device port, and returns read nibbles, IO status and the interrupt
//   request on the 4-bit return nibble.
//
//   Beat encodings on bus_in:
//     10AAAAAA  ALO  address bits [5:0]
//     11AAAAAA  AHI  address bits [11:6]
//     011W0III  IOI  IO intro
//     0BBWDDDD  data beat, BB = 00/01/10 -> D0/D1/D2, W = write
//
//   Ports:
//     clk, reset     clock, synchronous active-high reset
//     bus_in         CPU io_out byte
//     nib_out        return nibble to CPU ext_in
//     irq            level interrupt request
//     io_dev         IO device select (address bits [5:0])
//     io_wdata/io_wr IO write word and one-cycle strobe
//     io_rd/io_rdata IO read strobe and word (sampled while io_rd is high)
//     io_ready/skip  IO device status
//     err_count      out-of-order beat count
//
//   Build option: define BUS_ERR_EN to implement err_count as a saturating
//   counter; otherwise err_count is tied to 0.
//
//   state     | meaning
//   IDLE      | waiting for ALO; any other beat is ignored
//   ALO_SEEN  | low address latched, expecting AHI
//   ADDR_DONE | full address known, expecting IOI or D0
//   IO_SEEN   | IO intro accepted, expecting D0
//   D0        | D0 accepted, expecting D1
//   D1        | D1 accepted, expecting D2
module pdp8_bus_target #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  bus_in,
  output logic [3:0]  nib_out,
  input  logic        irq,
  output logic [5:0]  io_dev,
  output logic [11:0] io_wdata,
  output logic        io_wr,
  output logic        io_rd,
  input  logic [11:0] io_rdata,
  input  logic        io_ready,
  input  logic        io_skip,
  output logic [7:0]  err_count
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, ALO_SEEN, ADDR_DONE, IO_SEEN, D0, D1} state_t;

  state_t        state;
  logic [11:0]   mem [MEM_WORDS];
  logic [5:0]    alo;
  logic [AW-1:0] addr;
  logic [AW-1:0] ahi_addr;
  logic [11:0]   rword;
  logic [3:0]    nib0, nib1;
  logic          w, io_cyc, irq_s;
  logic [5:0]    io_dev_q;
  logic          legal, bad_beat, mem_we;

  logic is_alo, is_ahi, is_ioi, is_d0, is_d1, is_d2, beat_w;
  assign is_alo = (bus_in[7:6] == 2'b10);
  assign is_ahi = (bus_in[7:6] == 2'b11);
  assign is_ioi = (bus_in[7:5] == 3'b011) && !bus_in[3];
  assign is_d0  = (bus_in[7:5] == 3'b000);
  assign is_d1  = (bus_in[7:5] == 3'b001);
  assign is_d2  = (bus_in[7:5] == 3'b010);
  assign beat_w = bus_in[4];

  // Higher address bits alias onto the RAM.
  assign ahi_addr = AW'({bus_in[5:0], alo});

  always_comb begin
    legal = 1'b0;
    case (state)
      IDLE:      legal = is_alo;
      ALO_SEEN:  legal = is_ahi;
      ADDR_DONE: legal = is_ioi || is_d0;
      IO_SEEN:   legal = is_d0 && (beat_w == w);
      D0:        legal = is_d1 && (beat_w == w);
      D1:        legal = is_d2 && (beat_w == w);
      default:   legal = 1'b0;
    endcase
  end

  // A non-ALO beat while idle is treated as an idle bus, not a protocol error.
  assign bad_beat = !legal && (state != IDLE);

  always_comb begin
    nib_out = 4'h0;
    if (is_alo) begin
      nib_out = {3'b000, irq_s};
    end else if (legal) begin
      if (is_ioi)       nib_out = {2'b00, io_skip, io_ready};
      else if (!beat_w) begin
        if (is_d0)      nib_out = rword[11:8];
        else if (is_d1) nib_out = rword[7:4];
        else if (is_d2) nib_out = rword[3:0];
      end
    end
  end

  // The device must see its select during the read strobe, so the IOI beat
  // presents the latched low address before io_dev_q picks it up.
  assign io_rd  = !reset && (state == ADDR_DONE) && is_ioi && !beat_w;
  assign io_dev = (!reset && (state == ADDR_DONE) && is_ioi) ? alo : io_dev_q;

  assign mem_we = !reset && (state == D1) && legal && w && !io_cyc;

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= {bus_in[3:0], nib1, nib0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      alo      <= '0;
      addr     <= '0;
      rword    <= '0;
      nib0     <= '0;
      nib1     <= '0;
      w        <= 1'b0;
      io_cyc   <= 1'b0;
      irq_s    <= 1'b0;
      io_dev_q <= '0;
      io_wdata <= '0;
      io_wr    <= 1'b0;
    end else begin
      irq_s <= irq;
      io_wr <= 1'b0;
      if (!legal) begin
        // Resynchronise: an ALO always starts a fresh transfer.
        state <= is_alo ? ALO_SEEN : IDLE;
        if (is_alo) alo <= bus_in[5:0];
      end else begin
        case (state)
          IDLE: begin
            state <= ALO_SEEN;
            alo   <= bus_in[5:0];
          end
          ALO_SEEN: begin
            state <= ADDR_DONE;
            addr  <= ahi_addr;
            rword <= mem[ahi_addr];
          end
          ADDR_DONE: begin
            w <= beat_w;
            if (is_ioi) begin
              state    <= IO_SEEN;
              io_cyc   <= 1'b1;
              io_dev_q <= alo;
              if (!beat_w) rword <= io_rdata;
            end else begin
              state  <= D0;
              io_cyc <= 1'b0;
              nib0   <= bus_in[3:0];
            end
          end
          IO_SEEN: begin
            state <= D0;
            nib0  <= bus_in[3:0];
          end
          D0: begin
            state <= D1;
            nib1  <= bus_in[3:0];
          end
          D1: begin
            state <= IDLE;
            if (w && io_cyc) begin
              io_wr    <= 1'b1;
              io_wdata <= {bus_in[3:0], nib1, nib0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef BUS_ERR_EN
  logic [7:0] err_q;
  always_ff @(posedge clk) begin
    if (reset)                          err_q <= '0;
    else if (bad_beat && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end
  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_pdp8_bus_target.sv
module tb_pdp8_bus_target;
  localparam int MW = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  bus_in;
  logic [3:0]  nib_out;
  logic        irq;
  logic [5:0]  io_dev;
  logic [11:0] io_wdata;
  logic        io_wr;
  logic        io_rd;
  logic [11:0] io_rdata;
  logic        io_ready;
  logic        io_skip;
  logic [7:0]  err_count;

  pdp8_bus_target #(.MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .nib_out(nib_out), .irq(irq),
    .io_dev(io_dev), .io_wdata(io_wdata), .io_wr(io_wr), .io_rd(io_rd),
    .io_rdata(io_rdata), .io_ready(io_ready), .io_skip(io_skip),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: tracks the beats of the transfer in progress as a list
  // and judges each new beat against the legal sequence
  // ALO, AHI, [IOI], D0, D1, D2 with one W value after the address.
  typedef enum int {K_ALO, K_AHI, K_IOI, K_D0, K_D1, K_D2, K_BAD} kind_t;

  logic [11:0] m_mem [MW];
  logic [7:0]  m_txn [$];
  logic [11:0] m_rword;
  logic        m_irq;
  logic        m_wr_pend;
  logic [11:0] m_wdata;
  logic [5:0]  m_dev;
  int          m_errs;
  bit          rnd;

  function automatic kind_t kind(input logic [7:0] b);
    if (b[7]) return b[6] ? K_AHI : K_ALO;
    case (b[6:5])
      2'b00:   return K_D0;
      2'b01:   return K_D1;
      2'b10:   return K_D2;
      default: return b[3] ? K_BAD : K_IOI;
    endcase
  endfunction

  function automatic bit m_legal(input logic [7:0] b);
    int    n;
    int    idx;
    kind_t k;
    n = m_txn.size();
    k = kind(b);
    if (n == 0) return k == K_ALO;
    if (n == 1) return k == K_AHI;
    if (n == 2) return (k == K_IOI) || (k == K_D0);
    idx = n - 2 - ((kind(m_txn[2]) == K_IOI) ? 1 : 0);
    return (k == kind_t'(int'(K_D0) + idx)) && (b[4] == m_txn[2][4]);
  endfunction

  function automatic logic [7:0] exp_err();
`ifdef BUS_ERR_EN
    return (m_errs > 255) ? 8'hFF : 8'(m_errs);
`else
    return 8'h00;
`endif
  endfunction

  task automatic beat(input logic [7:0] b);
    kind_t       k;
    bit          lg, io;
    int          n;
    logic [3:0]  exp_nib;
    logic [11:0] a, word;
    bus_in  = b;
    k       = kind(b);
    lg      = m_legal(b);
    n       = m_txn.size();
    io      = (n >= 3) && (kind(m_txn[2]) == K_IOI);
    exp_nib = 4'h0;
    if (k == K_ALO) exp_nib = {3'b000, m_irq};
    else if (lg && k == K_IOI) exp_nib = {2'b00, io_skip, io_ready};
    else if (lg && !b[4] && (k == K_D0 || k == K_D1 || k == K_D2))
      exp_nib = 4'(m_rword >> (4 * (int'(K_D2) - int'(k))));

    @(negedge clk);
    check("nib_out", 32'(nib_out), 32'(exp_nib));
    check("io_rd", 32'(io_rd), 32'(lg && k == K_IOI && !b[4]));
    if (lg && k == K_IOI) check("io_dev_ioi", 32'(io_dev), 32'(m_txn[0][5:0]));
    check("io_wr", 32'(io_wr), 32'(m_wr_pend));
    if (m_wr_pend) begin
      check("io_wdata", 32'(io_wdata), 32'(m_wdata));
      check("io_dev_wr", 32'(io_dev), 32'(m_dev));
    end
    check("err_count", 32'(err_count), 32'(exp_err()));

    @(posedge clk);
    #1;
    m_wr_pend = 1'b0;
    if (lg) begin
      m_txn.push_back(b);
      if (m_txn.size() >= 2) a = {m_txn[1][5:0], m_txn[0][5:0]};
      else a = 12'h000;
      case (k)
        K_AHI: m_rword = m_mem[int'(a) % MW];
        K_IOI: begin
          m_dev = a[5:0];
          if (!b[4]) m_rword = io_rdata;
        end
        K_D2: begin
          word = {b[3:0], m_txn[n-1][3:0], m_txn[n-2][3:0]};
          if (b[4]) begin
            if (io) begin
              m_wr_pend = 1'b1;
              m_wdata   = word;
            end else begin
              m_mem[int'(a) % MW] = word;
            end
          end
          m_txn.delete();
        end
        default: ;
      endcase
    end else begin
      if (n > 0) m_errs++;
      m_txn.delete();
      if (k == K_ALO) m_txn.push_back(b);
    end
    m_irq = irq;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    bus_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    m_txn.delete();
    m_rword   = 12'h000;
    m_irq     = 1'b0;
    m_wr_pend = 1'b0;
    m_errs    = 0;
    check("rst_nib_out", 32'(nib_out), 32'h0);
    check("rst_io_wr", 32'(io_wr), 32'h0);
    check("rst_io_rd", 32'(io_rd), 32'h0);
    check("rst_io_dev", 32'(io_dev), 32'h0);
    check("rst_io_wdata", 32'(io_wdata), 32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);
  endtask

  task automatic rbeat(input logic [7:0] b);
    if (rnd) begin
      io_rdata = 12'($urandom);
      io_ready = 1'($urandom);
      io_skip  = 1'($urandom);
      irq      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) beat(8'($urandom));
    end
    beat(b);
  endtask

  task automatic txn(input bit io, input bit wr, input logic [11:0] a, input logic [11:0] d);
    rbeat({2'b10, a[5:0]});
    rbeat({2'b11, a[11:6]});
    if (io) rbeat({3'b011, wr, 1'b0, 3'($urandom)});
    rbeat({3'b000, wr, d[3:0]});
    rbeat({3'b001, wr, d[7:4]});
    rbeat({3'b010, wr, d[11:8]});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rnd      = 1'b0;
    irq      = 1'b0;
    io_rdata = 12'h000;
    io_ready = 1'b0;
    io_skip  = 1'b0;
    bus_in   = 8'h00;
    m_errs   = 0;
    do_reset();

    for (int i = 0; i < MW; i++) txn(1'b0, 1'b1, 12'(i), 12'($urandom));

    // Write then read 0o200.
    beat(8'h80); beat(8'hC2); beat(8'h1C); beat(8'h39); beat(8'h52);
    beat(8'h80); beat(8'hC2); beat(8'h00); beat(8'h20); beat(8'h40);

    // Interrupt shows on the ALO nibble.
    irq = 1'b1;
    beat(8'h00); beat(8'h00); beat(8'h80);
    irq = 1'b0;
    beat(8'h00); beat(8'h00); beat(8'h80);
    beat(8'hC2); beat(8'h00); beat(8'h20); beat(8'h40);

    // IO read of device 0o12.
    io_ready = 1'b1; io_skip = 1'b1; io_rdata = 12'o7654;
    beat(8'h8A); beat(8'hC0); beat(8'h61); beat(8'h00); beat(8'h20); beat(8'h40);

    // IO write to device 0o12, then RAM[10] must be untouched.
    beat(8'h8A); beat(8'hC0); beat(8'h74); beat(8'h15); beat(8'h36); beat(8'h57);
    beat(8'h00);
    txn(1'b0, 1'b0, 12'd10, 12'h000);

    // Out-of-order ALO during a write, then complete a read from the new ALO.
    beat(8'h80); beat(8'hC2); beat(8'h1C); beat(8'h81);
    beat(8'hC2); beat(8'h00); beat(8'h20); beat(8'h40);
    txn(1'b0, 1'b0, 12'o0200, 12'h000);

    // Reset in the middle of a write.
    beat(8'h80); beat(8'hC2); beat(8'h1C); beat(8'h39);
    do_reset();
    beat(8'h52);
    txn(1'b0, 1'b0, 12'o0200, 12'h000);

    // Randomized traffic.
    rnd = 1'b1;
    for (int t = 0; t < 700; t++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel == 0)       do_reset();
      else if (sel < 30)  txn(1'b0, 1'b1, 12'($urandom), 12'($urandom));
      else if (sel < 60)  txn(1'b0, 1'b0, 12'($urandom), 12'($urandom));
      else if (sel < 72)  txn(1'b1, 1'b0, 12'($urandom), 12'($urandom));
      else if (sel < 84)  txn(1'b1, 1'b1, 12'($urandom), 12'($urandom));
      else                rbeat(8'($urandom));
    end
    rnd = 1'b0;
    beat(8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pdp8_bus_target.md
Name: pdp8_bus_target

Overview:
- Bus-side target for the PDP-8 core's 8-bit multiplexed nibble bus. Sits directly downstream of the CPU's io_out pins and drives the CPU's 4-bit ext_in nibble.
- Decodes address, IO-intro and data beats.
- Owns a synchronous word RAM and one IO device port with a ready/skip handshake.
- Returns read nibbles, IO ready/skip status and the interrupt request on the nibble at the cycle positions the CPU samples them.

Parameters:
- MEM_WORDS, 256, RAM depth in 12-bit words. Power of two, 64..4096. Address uses the low log2(MEM_WORDS) bits; higher bits alias.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- bus_in  in  8  CPU io_out byte
- nib_out  out  4  to CPU ext_in (io_in[7:4])
- irq  in  1  level interrupt request from system
- io_dev  out  6  IO device select (latched address bits [5:0])
- io_wdata  out  12  IO write word
- io_wr  out  1  one-cycle IO write strobe
- io_rd  out  1  one-cycle IO read strobe
- io_rdata  in  12  IO read word, sampled on the io_rd cycle
- io_ready  in  1  device ready
- io_skip  in  1  device skip condition
- err_count  out  8  protocol error count (optional feature)

Behaviour:
- Beat decode on bus_in:
  - 10AAAAAA: ALO, A[5:0]
  - 11AAAAAA: AHI, A[11:6]
  - 011W0III: IOI, IO intro
  - 0BBWDDDD: data beat, BB=00/01/10 = D0/D1/D2, W=write
- States: IDLE (expect ALO) -> ALO_SEEN -> ADDR_DONE -> [IO_SEEN] -> D0 -> D1 -> D2 -> IDLE.
- ADDR_DONE is entered on the AHI edge. From ADDR_DONE, IOI goes to IO_SEEN; D0 goes straight to memory data.
- Memory read:
  - At the AHI edge, read RAM[{bus_in[5:0],alo}] into rword.
  - nib_out = rword[11:8] during D0, rword[7:4] during D1, rword[3:0] during D2. Combinational from state and rword.
- Memory write (W=1): wire order is low-first. D0 carries [3:0], D1 [7:4], D2 [11:8].
  - D0/D1 nibbles are latched.
  - On the D2 edge, write the full word to RAM. Write latency is 1 cycle; a read of the same address immediately after returns the new value.
- IO cycle:
  - On the IOI edge, io_dev = latched A[5:0].
  - If W=0: io_rd pulses that cycle and io_rdata is captured into rword. Data beats then return nibbles as for memory.
  - If W=1: io_wr pulses on the cycle after the D2 edge, with io_wdata = the assembled word.
  - IO cycles never touch RAM.
- nib_out per beat:
  - ALO beat: {3'b0, irq_s}. irq_s is irq registered once.
  - IOI beat: {2'b0, io_skip, io_ready}, combinational from the inputs.
  - Write data beats and IDLE: 0.
- Out-of-order beat, i.e. any beat not legal for the current state:
  - FSM returns to IDLE; an ALO beat is reprocessed as a fresh ALO.
  - A pending write is discarded and no strobe is issued.
  - W changing between D0 and D2 is an error.
- Reset, including mid-cycle:
  - FSM goes to IDLE; rword, latches, io_dev, io_wdata and irq_s clear to 0.
  - io_wr and io_rd are 0; err_count is 0.
  - A partial write is never committed. RAM contents are not cleared.

Optional Feature:
- BUS_ERR_EN defined:
  - err_count increments, saturating at 255, on every out-of-order beat.
  - Cleared only by reset.
- BUS_ERR_EN undefined:
  - err_count is tied to 0 and no counter flops exist.
  - Resynchronisation behaviour is unchanged.

Test Plan:
- Memory write then read of address 0o200:
  - Write bytes: 0x80, 0xC2, 0x1C, 0x39, 0x52. RAM[128] = 0o1234.
  - Read bytes: 0x80, 0xC2, 0x00, 0x20, 0x40. nib_out = 0x2, 0x9, 0xC.
- Interrupt: irq=1 two cycles before an ALO beat 0x80 -> nib_out=0x1 on that beat. With irq=0 -> 0x0.
- IO read of device 0o12:
  - Stimulus: io_ready=1, io_skip=1, io_rdata=0o7654; bytes 0x8A, 0xC0, 0x61, 0x00, 0x20, 0x40.
  - nib_out=0x3 on IOI.
  - io_rd pulses once with io_dev=0o12.
  - nib_out = 0xF, 0xA, 0xC on the data beats.
- IO write to device 0o12:
  - Bytes: 0x8A, 0xC0, 0x74, 0x15, 0x36, 0x57.
  - One io_wr pulse with io_wdata=0x765 and io_dev=0o12.
  - RAM[10] is unchanged.
- Protocol error:
  - Bytes: 0x80, 0xC2, 0x1C, then 0x81 (ALO).
  - No RAM write occurs and the FSM is in ALO_SEEN.
  - err_count=1 with BUS_ERR_EN defined, 0 without it.
- Reset mid-write:
  - reset asserted after 0x80, 0xC2, 0x1C, 0x39; then bytes 0x52 and a read of 0o200.
  - RAM[128] keeps its old value and nib_out stays 0 during the stray 0x52.
